// File: rtl/ocp_pkg.sv
// ocp_pkg: channel state encoding and counter sizing shared by the overcurrent guard
package ocp_pkg;
   typedef enum logic [1:0] {ST_ARMED, ST_COUNTING, ST_TRIPPED, ST_LOCKED} ch_state_t;
   function automatic int cnt_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction
endpackage

// File: rtl/ocp_channel.sv
// ocp_channel: one channel's trip/debounce/cooldown/lockout state machine
module ocp_channel
   import ocp_pkg::*;
#(
   parameter int unsigned WIDTH         = 12,
   parameter logic [WIDTH-1:0] TRIP_LEVEL    = 12'd2500,
   parameter logic [WIDTH-1:0] RELEASE_LEVEL = 12'd2300,
   parameter int unsigned TRIP_SAMPLES  = 8,
   parameter int unsigned RETRY_CYCLES  = 1000,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   input  logic             fault_clr,
   output logic             enable_out,
   output logic             fault_latched,
   output logic             trip_pulse
);
   localparam int CW = cnt_w(TRIP_SAMPLES);
   localparam int KW = cnt_w(RETRY_CYCLES);
   localparam int RW = cnt_w(MAX_RETRIES);
   localparam logic [CW-1:0] TS      = CW'(TRIP_SAMPLES);
   localparam logic [KW-1:0] RC_LAST = KW'(RETRY_CYCLES - 1);
   localparam logic [RW-1:0] MR      = RW'(MAX_RETRIES);
   ch_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] cool_q, cool_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          pulse_q, pulse_d;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cool_d  = '0;
      retry_d = retry_q;
      case (state_q)
         ST_ARMED, ST_COUNTING: begin
            if (fault_clr) retry_d = '0;
            if (sample_valid) begin
               if (sample >= TRIP_LEVEL) begin
                  state_d = (cnt_q + 1'b1 == TS) ? ST_TRIPPED : ST_COUNTING;
                  cnt_d   = (cnt_q + 1'b1 == TS) ? '0 : cnt_q + 1'b1;
               end else if (sample < RELEASE_LEVEL) begin
                  state_d = ST_ARMED;
                  cnt_d   = '0;
               end
            end
         end
         ST_TRIPPED: begin
            cool_d = cool_q + 1'b1;
            // a clear request beats both re-arm and lockout on the expiry edge
            if (fault_clr) begin
               state_d = ST_ARMED;
               retry_d = '0;
            end else if (cool_q == RC_LAST) begin
               state_d = (retry_q < MR) ? ST_ARMED : ST_LOCKED;
               retry_d = (retry_q < MR) ? retry_q + 1'b1 : retry_q;
            end
         end
         default: begin
            state_d = fault_clr ? ST_ARMED : ST_LOCKED;
            retry_d = fault_clr ? '0 : retry_q;
         end
      endcase
      pulse_d = (state_d == ST_TRIPPED) && (state_q != ST_TRIPPED);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ARMED;
         cnt_q   <= '0;
         cool_q  <= '0;
         retry_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cool_q  <= cool_d;
         retry_q <= retry_d;
         pulse_q <= pulse_d;
      end
   end
   assign enable_out    = (state_q == ST_ARMED) || (state_q == ST_COUNTING);
   assign fault_latched = (state_q == ST_LOCKED);
   assign trip_pulse    = pulse_q;
endmodule

// File: rtl/overcurrent_guard.sv
// overcurrent_guard: N_CH independent overcurrent trip channels between ADC samples and power enables
module overcurrent_guard
   import ocp_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned WIDTH         = 12,
   parameter logic [WIDTH-1:0] TRIP_LEVEL    = 12'd2500,
   parameter logic [WIDTH-1:0] RELEASE_LEVEL = 12'd2300,
   parameter int unsigned TRIP_SAMPLES  = 8,
   parameter int unsigned RETRY_CYCLES  = 1000,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       sample_valid,
   input  logic [N_CH*WIDTH-1:0] current_in,
   input  logic [N_CH-1:0]       fault_clr,
   output logic [N_CH-1:0]       enable_out,
   output logic [N_CH-1:0]       fault_latched,
   output logic [N_CH-1:0]       trip_pulse
);
   if (RELEASE_LEVEL > TRIP_LEVEL) begin : g_bad_release
      $error("RELEASE_LEVEL must not exceed TRIP_LEVEL");
   end
   if (TRIP_SAMPLES < 1) begin : g_bad_samples
      $error("TRIP_SAMPLES must be at least 1");
   end
   if (RETRY_CYCLES < 1) begin : g_bad_retry
      $error("RETRY_CYCLES must be at least 1");
   end
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      ocp_channel #(
         .WIDTH(WIDTH), .TRIP_LEVEL(TRIP_LEVEL), .RELEASE_LEVEL(RELEASE_LEVEL),
         .TRIP_SAMPLES(TRIP_SAMPLES), .RETRY_CYCLES(RETRY_CYCLES), .MAX_RETRIES(MAX_RETRIES)
      ) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .sample_valid(sample_valid[g]),
         .sample(current_in[g*WIDTH +: WIDTH]),
         .fault_clr(fault_clr[g]),
         .enable_out(enable_out[g]),
         .fault_latched(fault_latched[g]),
         .trip_pulse(trip_pulse[g])
      );
   end
endmodule
